// File: rtl/irq_ctrl_v1.sv
// irq_ctrl_v1: SFR-mapped interrupt controller.
// Peripheral event lines are edge-detected into sticky flags. The flags are
// masked by per-source and global enables, and the lowest pending index wins.
// A three-state FSM runs the req/ack/done handshake with the CPU. Only one
// interrupt can be in service at a time.
module irq_ctrl_v1 #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF854,
    parameter int                    N_SRC      = 12,
    parameter int                    ID_WIDTH   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic                  sys_wr_en,
    input  logic [DATA_WIDTH-1:0] sys_sw_value,
    output logic [DATA_WIDTH-1:0] sfr_rd_dout,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  irq_ack,
    input  logic                  irq_done,
    output logic                  irq_req,
    output logic [ID_WIDTH-1:0]   irq_id,
    output logic                  irq_active
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_IEN  = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IFLG = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ICON = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IVEC = BASE_ADDR + ADDR_WIDTH'(12);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0] id_reg, id_next;
    logic [N_SRC-1:0]    ien_reg;
    logic [N_SRC-1:0]    iflg_reg;
    logic [N_SRC-1:0]    src_prev_reg;
    logic                gie_reg;

    logic [N_SRC-1:0]    src_rise;
    logic [N_SRC-1:0]    sw_clr;
    logic [N_SRC-1:0]    ack_clr;
    logic [N_SRC-1:0]    pend;
    logic [ID_WIDTH-1:0] winner;
    logic                ack_fire;
    logic                sel_ien, sel_iflg, sel_icon, sel_ivec;

    // Write-data bits above N_SRC and above bit 0 of ICON are intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^sys_sw_value;

    assign sel_ien  = (sys_addr == ADDR_IEN);
    assign sel_iflg = (sys_addr == ADDR_IFLG);
    assign sel_icon = (sys_addr == ADDR_ICON);
    assign sel_ivec = (sys_addr == ADDR_IVEC);

    assign src_rise = irq_src & ~src_prev_reg;
    assign sw_clr   = (sys_wr_en && sel_iflg) ? sys_sw_value[N_SRC-1:0] : '0;
    assign ack_fire = (state_reg == ST_REQ) && irq_ack;
    assign pend     = iflg_reg & ien_reg & {N_SRC{gie_reg}};

    // Ack clears only the flag of the id that was presented to the CPU.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ack_clr
        assign ack_clr[gi] = ack_fire && (id_reg == ID_WIDTH'(gi));
    end

    // Fixed priority: the scan runs downwards, so the lowest pending index wins.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend[i]) winner = ID_WIDTH'(i);
        end
    end

    // Registers, edge history and flags. A new edge beats a same-cycle clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ien_reg      <= '0;
            iflg_reg     <= '0;
            src_prev_reg <= '0;
            gie_reg      <= 1'b0;
        end else begin
            src_prev_reg <= irq_src;
            iflg_reg     <= (iflg_reg & ~sw_clr & ~ack_clr) | src_rise;
            if (sys_wr_en && sel_ien)  ien_reg <= sys_sw_value[N_SRC-1:0];
            if (sys_wr_en && sel_icon) gie_reg <= sys_sw_value[0];
        end
    end

    // FSM state and id register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
        end
    end

    // Next state: REQ tracks the winner until ack. Ack beats withdraw in the same cycle.
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pend != '0) begin
                    state_next = ST_REQ;
                    id_next    = winner;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_next = ST_SERVICE;
                end else if (pend == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    id_next = winner;
                end
            end
            ST_SERVICE: begin
                if (irq_done) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign irq_req    = (state_reg == ST_REQ);
    assign irq_active = (state_reg == ST_SERVICE);
    assign irq_id     = id_reg;

    // Read mux. It drives zero when nothing is addressed, so the outputs can be OR-ed onto the bus.
    always_comb begin
        sfr_rd_dout = '0;
        if (sel_ien)  sfr_rd_dout = DATA_WIDTH'(ien_reg);
        if (sel_iflg) sfr_rd_dout = DATA_WIDTH'(iflg_reg);
        if (sel_icon) sfr_rd_dout = DATA_WIDTH'({irq_active, gie_reg});
        if (sel_ivec) sfr_rd_dout = DATA_WIDTH'(id_reg);
    end

endmodule
